// File: rtl/qsn_len15_pkg.sv
// ---------------------------------------------------------------------------
// qsn_len15_pkg
// Shared constants and the merge-select helper for the 15-lane, 3-bit-plane
// QSN cyclic shifter (Pc=15, q=3) and its feeder.
//   PC      number of lanes (messages per vector)
//   Q       number of bit-planes per message
//   SEL_W   width of left_sel / right_sel / shift amount
//   MERGE_W width of merge_sel (one select per lane 0..13)
// ---------------------------------------------------------------------------
package qsn_len15_pkg;

    localparam int PC      = 15;
    localparam int Q       = 3;
    localparam int SEL_W   = 4;
    localparam int MERGE_W = 14;

    // Lane k takes the right network when k >= PC - s. Shift 0 is the identity.
    // The illegal value 15 is also folded to identity, so the result is all zeros.
    function automatic logic [MERGE_W-1:0] decode_merge(input logic [SEL_W-1:0] s);
        logic [MERGE_W-1:0] m;
        m = '0;
        if (s != '0 && int'(s) < PC) begin
            for (int k = 0; k < MERGE_W; k++) begin
                m[k] = (k >= PC - int'(s));
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/qsn_feed_ctrl_len15_if.sv
// ---------------------------------------------------------------------------
// qsn_feed_ctrl_len15_if
// Upstream transaction bundle for the QSN feeder: valid/ready handshake, the
// cyclic-shift factor, three 15-bit bit-planes and an opaque tag.
//   master : drives in_valid, in_shift, in_bit0..2, in_tag; receives in_ready
//   slave  : receives the transaction fields; drives in_ready
// ---------------------------------------------------------------------------
interface qsn_feed_ctrl_len15_if #(
    parameter int TAG_W = 4
) ();
    import qsn_len15_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_shift;
    logic [PC-1:0]      in_bit0;
    logic [PC-1:0]      in_bit1;
    logic [PC-1:0]      in_bit2;
    logic [TAG_W-1:0]   in_tag;

    modport master (
        output in_valid, in_shift, in_bit0, in_bit1, in_bit2, in_tag,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_shift, in_bit0, in_bit1, in_bit2, in_tag,
        output in_ready
    );

endinterface

// File: rtl/qsn_feed_ctrl_len15_decode.sv
// ---------------------------------------------------------------------------
// qsn_shift_decode_len15
// Combinational decode of a cyclic left-rotation amount into the QSN select
// controls. Shift 0 and the illegal value 15 both decode to identity.
//   shift     in  4   rotation amount s
//   left_sel  out 4   s (0 for identity)
//   right_sel out 4   15 - s (0 for identity)
//   merge_sel out 14  per-lane right-network select
//   shift_bad out 1   s == 15
// ---------------------------------------------------------------------------
module qsn_shift_decode_len15
    import qsn_len15_pkg::*;
(
    input  logic [SEL_W-1:0]   shift,
    output logic [SEL_W-1:0]   left_sel,
    output logic [SEL_W-1:0]   right_sel,
    output logic [MERGE_W-1:0] merge_sel,
    output logic               shift_bad
);

    // Left/right networks rotate by complementary amounts; identity needs neither.
    always_comb begin
        left_sel  = '0;
        right_sel = '0;
        merge_sel = decode_merge(shift);
        shift_bad = (int'(shift) >= PC);
        if (shift != '0 && !shift_bad) begin
            left_sel  = shift;
            right_sel = SEL_W'(PC - int'(shift));
        end
    end

endmodule

// File: rtl/qsn_feed_ctrl_len15.sv
// ---------------------------------------------------------------------------
// qsn_feed_ctrl_len15
// Upstream feeder for the 15-lane QSN cyclic shifter. Accepts one message
// vector plus shift factor per handshake, registers the QSN drives, tracks the
// QSN latency so out_valid/out_tag line up with sw_out_bit*, and limits
// issue with a credit counter for the downstream buffer.
//   sys_clk, rst          clock, synchronous active-high reset
//   up (slave)            in_valid/in_ready/in_shift/in_bit0..2/in_tag
//   credit_ret            one-cycle pulse, downstream freed a slot
//   sw_in_bit0..2         registered QSN data drives
//   left/right/merge_sel  registered QSN select drives
//   out_valid, out_tag    transaction present at QSN output this cycle
//   credit_cnt            current credits
//   shift_err             sticky, an accepted shift was 15
// ---------------------------------------------------------------------------
module qsn_feed_ctrl_len15
    import qsn_len15_pkg::*;
#(
    parameter int QSN_LAT = 2,
    parameter int CREDITS = 4,
    parameter int TAG_W   = 4
) (
    input  logic                sys_clk,
    input  logic                rst,
    qsn_feed_ctrl_len15_if.slave up,
    input  logic                credit_ret,
    output logic [PC-1:0]       sw_in_bit0,
    output logic [PC-1:0]       sw_in_bit1,
    output logic [PC-1:0]       sw_in_bit2,
    output logic [SEL_W-1:0]    left_sel,
    output logic [SEL_W-1:0]    right_sel,
    output logic [MERGE_W-1:0]  merge_sel,
    output logic                out_valid,
    output logic [TAG_W-1:0]    out_tag,
    output logic [3:0]          credit_cnt,
    output logic                shift_err
);

    logic               accept;
    logic [SEL_W-1:0]   dec_left;
    logic [SEL_W-1:0]   dec_right;
    logic [MERGE_W-1:0] dec_merge;
    logic               dec_bad;
    logic               acc_q;
    logic [TAG_W-1:0]   tag_q;
    logic [QSN_LAT-1:0] vld_pipe;
    logic [TAG_W-1:0]   tag_pipe [QSN_LAT];

    assign up.in_ready = (credit_cnt != 4'd0);
    assign accept      = up.in_valid && up.in_ready;

    qsn_shift_decode_len15 u_decode (
        .shift     (up.in_shift),
        .left_sel  (dec_left),
        .right_sel (dec_right),
        .merge_sel (dec_merge),
        .shift_bad (dec_bad)
    );

    // Credit counter: an accept and a return in the same cycle cancel out;
    // a return when already full is dropped rather than wrapping.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            credit_cnt <= 4'(CREDITS);
        end else if (accept && !credit_ret) begin
            credit_cnt <= credit_cnt - 4'd1;
        end else if (credit_ret && !accept && credit_cnt != 4'(CREDITS)) begin
            credit_cnt <= credit_cnt + 4'd1;
        end
    end

    // Input register stage: the QSN cannot stall, so idle cycles drive zeros.
    always_ff @(posedge sys_clk) begin
        if (rst || !accept) begin
            sw_in_bit0 <= '0;
            sw_in_bit1 <= '0;
            sw_in_bit2 <= '0;
            left_sel   <= '0;
            right_sel  <= '0;
            merge_sel  <= '0;
            acc_q      <= 1'b0;
            tag_q      <= '0;
        end else begin
            sw_in_bit0 <= up.in_bit0;
            sw_in_bit1 <= up.in_bit1;
            sw_in_bit2 <= up.in_bit2;
            left_sel   <= dec_left;
            right_sel  <= dec_right;
            merge_sel  <= dec_merge;
            acc_q      <= 1'b1;
            tag_q      <= up.in_tag;
        end
    end

    // Sticky illegal-shift flag, cleared only by reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            shift_err <= 1'b0;
        end else if (accept && dec_bad) begin
            shift_err <= 1'b1;
        end
    end

    // Valid/tag delay line matching the QSN latency; every slot advances
    // each cycle so the output timing never shifts.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < QSN_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= acc_q;
            tag_pipe[0] <= tag_q;
            for (int i = 1; i < QSN_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign out_valid = vld_pipe[QSN_LAT-1];
    assign out_tag   = tag_pipe[QSN_LAT-1];

endmodule

// File: tb/tb_qsn_feed_ctrl_len15.sv
// ---------------------------------------------------------------------------
// tb_qsn_feed_ctrl_len15
// Directed plus randomized bench for the QSN feeder, checked against a
// cycle-indexed reference model of credits, decode and output timing.
// ---------------------------------------------------------------------------
module tb_qsn_feed_ctrl_len15;

    localparam int NSLOT = 1024;

    logic        sys_clk;
    logic        rst;
    logic        credit_ret;
    logic [14:0] sw_in_bit0;
    logic [14:0] sw_in_bit1;
    logic [14:0] sw_in_bit2;
    logic [3:0]  left_sel;
    logic [3:0]  right_sel;
    logic [13:0] merge_sel;
    logic        out_valid;
    logic [3:0]  out_tag;
    logic [3:0]  credit_cnt;
    logic        shift_err;

    int compared;
    int mismatched;

    // Reference model state
    int          cyc;
    int          cred_m;
    logic        err_m;
    logic        exp_vld [NSLOT];
    logic [3:0]  exp_tag [NSLOT];
    logic [14:0] exp_b0, exp_b1, exp_b2;
    logic [3:0]  exp_l, exp_r;
    logic [13:0] exp_m;

    qsn_feed_ctrl_len15_if #(.TAG_W(4)) up_if ();

    qsn_feed_ctrl_len15 #(
        .QSN_LAT (2),
        .CREDITS (4),
        .TAG_W   (4)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .up         (up_if),
        .credit_ret (credit_ret),
        .sw_in_bit0 (sw_in_bit0),
        .sw_in_bit1 (sw_in_bit1),
        .sw_in_bit2 (sw_in_bit2),
        .left_sel   (left_sel),
        .right_sel  (right_sel),
        .merge_sel  (merge_sel),
        .out_valid  (out_valid),
        .out_tag    (out_tag),
        .credit_cnt (credit_cnt),
        .shift_err  (shift_err)
    );

    // Free-running 10 ns clock
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic checkRegistered();
        checkOutput("sw_in_bit0", 32'(sw_in_bit0), 32'(exp_b0));
        checkOutput("sw_in_bit1", 32'(sw_in_bit1), 32'(exp_b1));
        checkOutput("sw_in_bit2", 32'(sw_in_bit2), 32'(exp_b2));
        checkOutput("left_sel", 32'(left_sel), 32'(exp_l));
        checkOutput("right_sel", 32'(right_sel), 32'(exp_r));
        checkOutput("merge_sel", 32'(merge_sel), 32'(exp_m));
        checkOutput("out_valid", 32'(out_valid), 32'(exp_vld[cyc % NSLOT]));
        checkOutput("out_tag", 32'(out_tag), 32'(exp_tag[cyc % NSLOT]));
        checkOutput("credit_cnt", 32'(credit_cnt), 32'(cred_m));
        checkOutput("shift_err", 32'(shift_err), 32'(err_m));
    endtask

    // One clock of stimulus: in_ready checked before the edge, everything else after.
    task automatic applyStimulus(input bit v, input logic [3:0] s, input logic [14:0] b0,
                                 input logic [14:0] b1, input logic [14:0] b2,
                                 input logic [3:0] tag, input bit cret);
        bit acc;
        bit legal;
        up_if.in_valid = v;
        up_if.in_shift = s;
        up_if.in_bit0  = b0;
        up_if.in_bit1  = b1;
        up_if.in_bit2  = b2;
        up_if.in_tag   = tag;
        credit_ret     = cret;
        @(negedge sys_clk);
        checkOutput("in_ready", 32'(up_if.in_ready), 32'(cred_m != 0));
        acc = v && (cred_m != 0);
        @(posedge sys_clk);
        cyc++;
        exp_vld[(cyc + 2) % NSLOT] = 1'b0;
        exp_tag[(cyc + 2) % NSLOT] = 4'd0;
        if (acc) begin
            legal  = (s != 4'd0) && (s != 4'd15);
            exp_b0 = b0;
            exp_b1 = b1;
            exp_b2 = b2;
            exp_l  = legal ? s : 4'd0;
            exp_r  = legal ? 4'(15 - int'(s)) : 4'd0;
            // The top s lanes of 15 take the right net; lane 14 has no select bit.
            exp_m  = legal ? 14'((((1 << int'(s)) - 1) << (15 - int'(s))) & 32'h3FFF) : 14'd0;
            if (s == 4'd15) err_m = 1'b1;
            exp_vld[(cyc + 2) % NSLOT] = 1'b1;
            exp_tag[(cyc + 2) % NSLOT] = tag;
        end else begin
            exp_b0 = '0; exp_b1 = '0; exp_b2 = '0;
            exp_l = '0; exp_r = '0; exp_m = '0;
        end
        if (acc && !cret) cred_m--;
        else if (cret && !acc && cred_m < 4) cred_m++;
        #1;
        checkRegistered();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 4'd0, 15'd0, 15'd0, 15'd0, 4'd0, 0);
    endtask

    task automatic resetStep(input int n);
        rst = 1'b1;
        up_if.in_valid = 1'b0;
        credit_ret = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            exp_vld[i] = 1'b0;
            exp_tag[i] = 4'd0;
        end
        cred_m = 4;
        err_m  = 1'b0;
        exp_b0 = '0; exp_b1 = '0; exp_b2 = '0;
        exp_l = '0; exp_r = '0; exp_m = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            cyc++;
        end
        #1;
        checkRegistered();
        checkOutput("in_ready_rst", 32'(up_if.in_ready), 32'd1);
        rst = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        rst        = 1'b1;
        credit_ret = 1'b0;
        up_if.in_valid = 1'b0;
        up_if.in_shift = '0;
        up_if.in_bit0  = '0;
        up_if.in_bit1  = '0;
        up_if.in_bit2  = '0;
        up_if.in_tag   = '0;

        $display("[TB] reset release and idle");
        resetStep(3);
        idle(10);

        $display("[TB] single accept s=3 tag=5");
        applyStimulus(1, 4'd3, 15'h1234, 15'h5678, 15'h0ABC, 4'd5, 0);
        checkOutput("s3_merge_const", 32'(merge_sel), 32'h3000);
        idle(3);
        applyStimulus(0, 4'd0, 15'd0, 15'd0, 15'd0, 4'd0, 1);

        $display("[TB] back-to-back until credits run out");
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 4'(i + 1), 15'(i * 977), 15'(i * 31), 15'(~i), 4'(i + 8), 0);
        checkOutput("credit_zero", 32'(credit_cnt), 32'd0);
        applyStimulus(1, 4'd7, 15'h7FFF, 15'h0001, 15'h4000, 4'd2, 1);
        applyStimulus(1, 4'd7, 15'h7FFF, 15'h0001, 15'h4000, 4'd3, 0);
        applyStimulus(1, 4'd9, 15'h2AAA, 15'h5555, 15'h1111, 4'd4, 0);
        idle(3);

        $display("[TB] credit corner cases");
        applyStimulus(0, 4'd0, 15'd0, 15'd0, 15'd0, 4'd0, 1);
        applyStimulus(0, 4'd0, 15'd0, 15'd0, 15'd0, 4'd0, 1);
        applyStimulus(1, 4'd14, 15'h0F0F, 15'h3C3C, 15'h6666, 4'd6, 1);
        checkOutput("credit_hold2", 32'(credit_cnt), 32'd2);
        applyStimulus(0, 4'd0, 15'd0, 15'd0, 15'd0, 4'd0, 1);
        applyStimulus(0, 4'd0, 15'd0, 15'd0, 15'd0, 4'd0, 1);
        applyStimulus(0, 4'd0, 15'd0, 15'd0, 15'd0, 4'd0, 1);
        checkOutput("credit_sat4", 32'(credit_cnt), 32'd4);

        $display("[TB] illegal shift 15");
        applyStimulus(1, 4'd15, 15'h1357, 15'h2468, 15'h7531, 4'd9, 0);
        idle(3);
        checkOutput("shift_err_sticky", 32'(shift_err), 32'd1);

        $display("[TB] reset with two in flight");
        applyStimulus(1, 4'd1, 15'h0011, 15'h0022, 15'h0033, 4'd1, 1);
        applyStimulus(1, 4'd2, 15'h0044, 15'h0055, 15'h0066, 4'd2, 1);
        resetStep(1);
        idle(4);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                          15'($urandom()), 15'($urandom()), 15'($urandom()),
                          4'($urandom()), $urandom_range(0, 2) == 0);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
